// File: rtl/esdi_cmd_sequencer.sv
// ESDI serial command/status sequencer.
// Takes 16-bit command words from a small FIFO and shifts each one out to the drive over
// the ESDI command-data / transfer-req / transfer-ack handshake (MSB first, odd parity last).
// A query transaction then shifts in 17 configuration/status bits from the drive. Every
// completed or timed-out transaction posts one response word into a response FIFO.
// Ports:
//   csr_aclk, csr_areset           clock, synchronous active-high reset
//   cmd_valid/ready/data/query/tag command FIFO write side
//   resp_valid/ready/data/tag/...  response FIFO read side (head of FIFO)
//   abort                          pulse: drop current transaction and flush commands
//   busy, cmd_level, irq           status
//   esdi_*                         drive interface, all active low
module esdi_cmd_sequencer #(
  parameter int unsigned DATA_SETUP  = 6,
  parameter int unsigned ACK_TO_NREQ = 6,
  parameter int unsigned BIT_TIMEOUT = 1_000_000,
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned RESP_DEPTH  = 4,
  parameter int unsigned MAX_RETRIES = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         csr_aclk,
  input  logic                         csr_areset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [15:0]                  cmd_data,
  input  logic                         cmd_query,
  input  logic [3:0]                   cmd_tag,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [15:0]                  resp_data,
  output logic [3:0]                   resp_tag,
  output logic                         resp_parity_err,
  output logic                         resp_timeout,
  output logic [2:0]                   resp_retries,
  input  logic                         abort,
  output logic                         busy,
  output logic [$clog2(CMD_DEPTH):0]   cmd_level,
  output logic                         irq,
  output logic                         esdi_transfer_req,
  output logic                         esdi_command_data,
  input  logic                         esdi_transfer_ack,
  input  logic                         esdi_confstat_data
);

  localparam int unsigned CAW = $clog2(CMD_DEPTH);
  localparam int unsigned RAW = $clog2(RESP_DEPTH);
  localparam logic [31:0] SetupLast   = 32'(DATA_SETUP - 1);
  localparam logic [31:0] HoldLast    = 32'(ACK_TO_NREQ - 1);
  localparam logic [31:0] TimeoutLast = 32'(BIT_TIMEOUT - 1);
  localparam logic [2:0]  MaxRetries  = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StIdle, StSetup, StWaitAck, StHold, StWaitNack, StRecover, StPost
  } state_e;

  state_e      state_q;
  logic        req_q, dat_q;
  logic [16:0] sh_q, rx_q;
  logic [4:0]  bit_cnt_q;
  logic        read_q, tmo_q;
  logic [2:0]  retry_q;
  logic [20:0] cmd_q;        // {query, tag, data} of the transaction in flight
  logic [31:0] cnt_q;

  logic [SYNC_STAGES-1:0] ack_sync_q, conf_sync_q;
  logic ack_s, conf_s;

  // Command FIFO
  logic [20:0]  cmd_mem [CMD_DEPTH];
  logic [CAW:0] cmd_wptr_q, cmd_rptr_q;
  logic         cmd_empty, cmd_full, cmd_push, cmd_pop;
  logic [20:0]  cmd_head;

  // Response FIFO
  logic [24:0]  resp_mem [RESP_DEPTH];
  logic [RAW:0] resp_wptr_q, resp_rptr_q;
  logic         resp_empty, resp_full, resp_push, resp_pop;
  logic [24:0]  resp_word;
  logic         is_query_ok;

  assign cmd_empty = (cmd_wptr_q == cmd_rptr_q);
  assign cmd_full  = (cmd_wptr_q[CAW] != cmd_rptr_q[CAW]) &&
                     (cmd_wptr_q[CAW-1:0] == cmd_rptr_q[CAW-1:0]);
  assign cmd_ready = !cmd_full;
  assign cmd_push  = cmd_valid && !cmd_full && !abort;
  assign cmd_pop   = (state_q == StIdle) && !cmd_empty && !abort;
  assign cmd_head  = cmd_mem[cmd_rptr_q[CAW-1:0]];
  assign cmd_level = cmd_wptr_q - cmd_rptr_q;

  assign resp_empty = (resp_wptr_q == resp_rptr_q);
  assign resp_full  = (resp_wptr_q[RAW] != resp_rptr_q[RAW]) &&
                      (resp_wptr_q[RAW-1:0] == resp_rptr_q[RAW-1:0]);
  assign resp_valid = !resp_empty;
  assign resp_pop   = resp_valid && resp_ready;
  assign resp_push  = (state_q == StPost) && !resp_full && !abort;
  assign irq        = !resp_empty;
  assign {resp_data, resp_tag, resp_parity_err, resp_timeout, resp_retries} =
      resp_mem[resp_rptr_q[RAW-1:0]];

  // Received word only means something for a query that did not time out.
  assign is_query_ok = cmd_q[20] && !tmo_q;
  assign resp_word   = {is_query_ok ? rx_q[16:1] : 16'h0, cmd_q[19:16],
                        is_query_ok && !(^rx_q), tmo_q, retry_q};

  assign busy              = (state_q != StIdle) || !cmd_empty;
  assign esdi_transfer_req = req_q;
  assign esdi_command_data = dat_q;
  assign ack_s             = ack_sync_q[SYNC_STAGES-1];
  assign conf_s            = conf_sync_q[SYNC_STAGES-1];

  always_ff @(posedge csr_aclk) begin
    if (csr_areset) begin
      ack_sync_q  <= '1;
      conf_sync_q <= '1;
    end else begin
      ack_sync_q  <= {ack_sync_q[SYNC_STAGES-2:0], esdi_transfer_ack};
      conf_sync_q <= {conf_sync_q[SYNC_STAGES-2:0], esdi_confstat_data};
    end
  end

  always_ff @(posedge csr_aclk) begin
    if (csr_areset || abort) begin
      cmd_wptr_q <= '0;
      cmd_rptr_q <= '0;
    end else begin
      if (cmd_push) cmd_wptr_q <= cmd_wptr_q + 1'b1;
      if (cmd_pop)  cmd_rptr_q <= cmd_rptr_q + 1'b1;
    end
  end

  always_ff @(posedge csr_aclk) begin
    if (cmd_push) cmd_mem[cmd_wptr_q[CAW-1:0]] <= {cmd_query, cmd_tag, cmd_data};
  end

  always_ff @(posedge csr_aclk) begin
    if (csr_areset) begin
      resp_wptr_q <= '0;
      resp_rptr_q <= '0;
    end else begin
      if (resp_push) resp_wptr_q <= resp_wptr_q + 1'b1;
      if (resp_pop)  resp_rptr_q <= resp_rptr_q + 1'b1;
    end
  end

  always_ff @(posedge csr_aclk) begin
    if (resp_push) resp_mem[resp_wptr_q[RAW-1:0]] <= resp_word;
  end

  always_ff @(posedge csr_aclk) begin
    if (csr_areset || abort) begin
      state_q   <= StIdle;
      req_q     <= 1'b1;
      dat_q     <= 1'b1;
      cnt_q     <= '0;
      sh_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      read_q    <= 1'b0;
      tmo_q     <= 1'b0;
      retry_q   <= '0;
      cmd_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          req_q <= 1'b1;
          dat_q <= 1'b1;
          if (cmd_pop) begin
            cmd_q     <= cmd_head;
            sh_q      <= {cmd_head[15:0], ~^cmd_head[15:0]};
            rx_q      <= '0;
            bit_cnt_q <= '0;
            read_q    <= 1'b0;
            retry_q   <= '0;
            tmo_q     <= 1'b0;
            cnt_q     <= '0;
            dat_q     <= ~cmd_head[15];
            state_q   <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == SetupLast) begin
            req_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= StWaitAck;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StWaitAck, StWaitNack: begin
          if ((state_q == StWaitAck) && !ack_s) begin
            if (read_q) rx_q <= {rx_q[15:0], ~conf_s};
            cnt_q   <= '0;
            state_q <= StHold;
          end else if ((state_q == StWaitNack) && ack_s) begin
            cnt_q <= '0;
            if (bit_cnt_q != 5'd16) begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
              sh_q      <= {sh_q[15:0], 1'b0};
              dat_q     <= read_q ? 1'b1 : ~sh_q[15];
              state_q   <= StSetup;
            end else if (cmd_q[20] && !read_q) begin
              read_q    <= 1'b1;
              bit_cnt_q <= '0;
              dat_q     <= 1'b1;
              state_q   <= StSetup;
            end else begin
              dat_q   <= 1'b1;
              state_q <= StPost;
            end
          end else if (cnt_q == TimeoutLast) begin
            req_q <= 1'b1;
            dat_q <= 1'b1;
            cnt_q <= '0;
            if (retry_q < MaxRetries) begin
              retry_q <= retry_q + 3'd1;
              state_q <= StRecover;
            end else begin
              tmo_q   <= 1'b1;
              state_q <= StPost;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StHold: begin
          if (cnt_q == HoldLast) begin
            req_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= StWaitNack;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StRecover: begin
          // Drive must release ack before the whole transaction is replayed from bit 0.
          if (ack_s) begin
            sh_q      <= {cmd_q[15:0], ~^cmd_q[15:0]};
            rx_q      <= '0;
            bit_cnt_q <= '0;
            read_q    <= 1'b0;
            cnt_q     <= '0;
            dat_q     <= ~cmd_q[15];
            state_q   <= StSetup;
          end else if (cnt_q == TimeoutLast) begin
            // Ack stuck low: give up rather than retry into a wedged drive.
            tmo_q   <= 1'b1;
            state_q <= StPost;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StPost: begin
          req_q <= 1'b1;
          dat_q <= 1'b1;
          if (!resp_full) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_esdi_cmd_sequencer.sv
// Self-checking bench for esdi_cmd_sequencer: a behavioural drive model answers the
// handshake, expected responses go into a scoreboard queue, and a monitor compares each
// popped response against it.
module tb_esdi_cmd_sequencer;

  localparam int unsigned CMD_DEPTH  = 4;
  localparam int unsigned RESP_DEPTH = 4;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  tag;
    logic        perr;
    logic        tmo;
    logic [2:0]  rtr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_query;
  logic [15:0] cmd_data;
  logic [3:0]  cmd_tag;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_data;
  logic [3:0]  resp_tag;
  logic        resp_parity_err, resp_timeout;
  logic [2:0]  resp_retries;
  logic        abort, busy, irq;
  logic [2:0]  cmd_level;
  logic        req, dat, ack, conf;

  int          n_checks = 0;
  int          n_pass   = 0;
  exp_t        exp_q[$];

  // Drive model controls
  logic        ack_en = 1'b1;
  logic        drv_query = 1'b0;
  logic [16:0] drv_word = '0;
  int          drv_base = 0;
  int          drv_dly = 3;
  int          rr_mode = 1;  // 0: hold off, 1: always ready, 2: random
  int          req_falls = 0;
  logic        cap_mem [4096];

  esdi_cmd_sequencer #(
    .DATA_SETUP (6),
    .ACK_TO_NREQ(6),
    .BIT_TIMEOUT(50),
    .CMD_DEPTH  (CMD_DEPTH),
    .RESP_DEPTH (RESP_DEPTH),
    .MAX_RETRIES(2),
    .SYNC_STAGES(2)
  ) dut (
    .csr_aclk          (clk),
    .csr_areset        (rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_data          (cmd_data),
    .cmd_query         (cmd_query),
    .cmd_tag           (cmd_tag),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_data         (resp_data),
    .resp_tag          (resp_tag),
    .resp_parity_err   (resp_parity_err),
    .resp_timeout      (resp_timeout),
    .resp_retries      (resp_retries),
    .abort             (abort),
    .busy              (busy),
    .cmd_level         (cmd_level),
    .irq               (irq),
    .esdi_transfer_req (req),
    .esdi_command_data (dat),
    .esdi_transfer_ack (ack),
    .esdi_confstat_data(conf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  // Odd-parity bit for a 16-bit word
  function automatic logic par_of(input logic [15:0] w);
    return ($countones(w) % 2) == 0;
  endfunction

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : ready_gen
    resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       resp_ready = 1'b0;
        1:       resp_ready = 1'b1;
        default: resp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Counts req pulses and records the command-data bit seen at each falling req.
  initial begin : req_counter
    logic prev_req;
    prev_req = 1'b1;
    forever begin
      @(negedge clk);
      if (prev_req && !req) begin
        cap_mem[req_falls % 4096] = !dat;
        req_falls++;
      end
      prev_req = req;
    end
  end

  // Drive: ack each req pulse after a delay; in a query's second 17 pulses, present status.
  initial begin : drive
    int d, k, idx;
    ack  = 1'b1;
    conf = 1'b1;
    forever begin
      @(negedge clk);
      if (ack_en && !req) begin
        d = (drv_dly != 0) ? drv_dly : int'($urandom_range(1, 5));
        repeat (d) @(negedge clk);
        idx = req_falls - drv_base - 1;
        if (drv_query && idx >= 17 && idx < 34) conf = !drv_word[33 - idx];
        ack = 1'b0;
        k = 0;
        while (!req && k < 200) begin
          @(negedge clk);
          k++;
        end
        d = (drv_dly != 0) ? drv_dly : int'($urandom_range(1, 5));
        repeat (d) @(negedge clk);
        ack  = 1'b1;
        conf = 1'b1;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL resp_unexpected: got tag 0x%0h data 0x%0h, required no response",
                   resp_tag, resp_data);
        end else begin
          e = exp_q.pop_front();
          chk("resp", {7'd0, resp_data, resp_tag, resp_parity_err, resp_timeout, resp_retries},
              {7'd0, e});
        end
      end
    end
  end

  task automatic push_cmd(input logic q, input logic [15:0] d, input logic [3:0] t);
    int n;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("cmd_ready_wait", 32'(n < 1000), 32'd1);
    cmd_valid = 1'b1;
    cmd_query = q;
    cmd_data  = d;
    cmd_tag   = t;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || resp_valid || exp_q.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  task automatic run_txn(input logic q, input logic [15:0] d, input logic [3:0] t,
                         input logic [15:0] rd, input logic flip);
    int          base;
    logic [16:0] wb;
    logic        rp;
    exp_t        e;
    rp        = par_of(rd) ^ flip;
    base      = req_falls;
    drv_base  = base;
    drv_query = q;
    drv_word  = {rd, rp};
    e.data    = q ? rd : 16'h0;
    e.tag     = t;
    e.perr    = q & ((($countones(rd) + int'(rp)) % 2) == 0);
    e.tmo     = 1'b0;
    e.rtr     = 3'd0;
    exp_q.push_back(e);
    push_cmd(q, d, t);
    wait_done("txn_done", 4000);
    chk("req_pulses", 32'(req_falls - base), q ? 32'd34 : 32'd17);
    for (int i = 0; i < 17; i++) wb[16-i] = cap_mem[(base + i) % 4096];
    chk("write_bits", 32'(wb), 32'({d, par_of(d)}));
  endtask

  initial begin : main
    int   base, n;
    exp_t e;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_query = 1'b0;
    cmd_data = '0;
    cmd_tag = '0;
    abort = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_req", 32'(req), 32'd1);
    chk("rst_data", 32'(dat), 32'd1);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_cmd_level", 32'(cmd_level), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Plain command, query with good parity, query with flipped parity
    run_txn(1'b0, 16'h1234, 4'h5, 16'h0000, 1'b0);
    run_txn(1'b1, 16'h0000, 4'h9, 16'hA5C3, 1'b0);
    run_txn(1'b1, 16'h0000, 4'hA, 16'hA5C3, 1'b1);

    // Drive never acks: two retries then a timeout response
    ack_en = 1'b0;
    base = req_falls;
    e = '{16'h0, 4'hC, 1'b0, 1'b1, 3'd2};
    exp_q.push_back(e);
    push_cmd(1'b0, 16'hBEEF, 4'hC);
    wait_done("timeout_done", 2000);
    chk("timeout_attempts", 32'(req_falls - base), 32'd3);
    ack_en = 1'b1;

    // FIFO back-pressure: one in flight, CMD_DEPTH queued, one refused, POST stalls
    rr_mode = 0;
    drv_query = 1'b0;
    base = req_falls;
    for (int i = 0; i <= CMD_DEPTH; i++) begin
      e = '{16'h0, 4'(i + 1), 1'b0, 1'b0, 3'd0};
      exp_q.push_back(e);
      push_cmd(1'b0, 16'(16'h0100 + i), 4'(i + 1));
      if (i == 0) begin
        @(posedge clk);
        #1;
      end
    end
    chk("full_level", 32'(cmd_level), CMD_DEPTH);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1;
    cmd_data  = 16'hDEAD;
    cmd_tag   = 4'hF;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("refused_level", 32'(cmd_level), CMD_DEPTH);
    n = 0;
    while ((req_falls - base) < 85 && n < 8000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (150) @(posedge clk);
    #1;
    chk("stall_pulses", 32'(req_falls - base), 32'd85);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_cmd_level", 32'(cmd_level), 32'd0);
    chk("stall_irq", 32'(irq), 32'd1);
    chk("stall_req", 32'(req), 32'd1);
    chk("stall_pending", 32'(exp_q.size()), RESP_DEPTH + 1);
    rr_mode = 1;
    wait_done("drain_done", 1000);

    // Abort mid-query: queued commands and a coincident push are all dropped
    base = req_falls;
    drv_base = base;
    drv_query = 1'b1;
    drv_word = 17'h1FFFF;
    push_cmd(1'b1, 16'h0F0F, 4'h3);
    n = 0;
    while ((req_falls - base) < 10 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    push_cmd(1'b0, 16'h1111, 4'h4);
    push_cmd(1'b0, 16'h2222, 4'h6);
    cmd_valid = 1'b1;
    cmd_data  = 16'h3333;
    abort     = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    chk("abort_req", 32'(req), 32'd1);
    chk("abort_data", 32'(dat), 32'd1);
    chk("abort_level", 32'(cmd_level), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (100) @(posedge clk);
    #1;
    chk("abort_no_resp", 32'(resp_valid), 32'd0);

    // Reset mid-command abandons it without a response
    base = req_falls;
    drv_base = base;
    drv_query = 1'b0;
    push_cmd(1'b0, 16'h7777, 4'h7);
    n = 0;
    while ((req_falls - base) < 5 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_req", 32'(req), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("rst_mid_no_resp", 32'(resp_valid), 32'd0);

    // Randomized mix with random ack timing and response back-pressure
    drv_dly = 0;
    rr_mode = 2;
    for (int i = 0; i < 12; i++) begin
      run_txn(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom),
              16'($urandom), ($urandom_range(0, 3) == 0));
    end
    rr_mode = 1;

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
